// File: rtl/dda_multi_axis.sv
// dda_multi_axis: multi-channel DDA step generator.
// NUM_AXES accumulators share one command FIFO, one tick divider and one slot
// sequencer. Each FIFO entry carries one signed velocity per axis and is
// executed for SLOT_TICKS ticks. Step pulses are delayed one cycle behind the
// tick so that step_dir always settles before a rising edge.
module dda_multi_axis #(
  parameter int NUM_AXES   = 2,
  parameter int VEL_W      = 8,
  parameter int ACC_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 100,
  parameter int SLOT_TICKS = 10,
  parameter int PULSE_CYC  = 50,
  parameter int ACC_INIT   = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr,
  input  logic [NUM_AXES*VEL_W-1:0]          cmd_data,
  input  logic [ACC_W-1:0]                   n_div,
  input  logic                               flush,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
  output logic                               overflow,
  output logic                               underrun,
  output logic                               busy,
  output logic                               slot_tick,
  output logic [NUM_AXES-1:0]                step_pulse,
  output logic [NUM_AXES-1:0]                step_dir
);

  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int MAG_W  = VEL_W - 1;
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int SLOT_W = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
  localparam int PCNT_W = $clog2(PULSE_CYC + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOT_TICKS - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL   = LVL_W'(FIFO_DEPTH);
  localparam logic [PCNT_W-1:0] PULSE_LOAD = PCNT_W'(PULSE_CYC);
  localparam logic [ACC_W-1:0]  ACC_RST    = ACC_W'(ACC_INIT);

  logic [DIV_W-1:0]  div_cnt;
  logic [SLOT_W-1:0] slot_cnt;
  logic              tick;
  logic              load_tick;

  logic [NUM_AXES*VEL_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          rd_ptr;
  logic [PTR_W-1:0]          wr_ptr;
  logic [LVL_W-1:0]          count;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop;
  logic                      push;
  logic [NUM_AXES*VEL_W-1:0] head;

  logic [MAG_W-1:0]  mag      [NUM_AXES];
  logic [MAG_W-1:0]  eff_mag  [NUM_AXES];
  logic [ACC_W-1:0]  acc      [NUM_AXES];
  logic [ACC_W-1:0]  acc_nxt  [NUM_AXES];
  logic [ACC_W:0]    sum      [NUM_AXES];
  logic [ACC_W:0]    diff     [NUM_AXES];
  logic [NUM_AXES-1:0] fire_nxt;
  logic [NUM_AXES-1:0] fire_q;
  logic [PCNT_W-1:0] pulse_cnt [NUM_AXES];

  assign tick       = (div_cnt == DIV_LAST);
  assign load_tick  = tick && (slot_cnt == '0);
  assign fifo_full  = (count == LVL_FULL);
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];
  // A flush suppresses both the pop and the write; a pop frees room for a write in the same cycle
  assign pop        = load_tick && !flush && !fifo_empty;
  assign push       = wr && !flush && (!fifo_full || pop);

  assign full  = fifo_full;
  assign empty = fifo_empty;
  assign level = count;

  // Tick divider and slot sequencer; the first tick after reset lands in slot position 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      slot_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) slot_cnt <= (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
    end
  end

  // FIFO storage; data needs no reset because count guards every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // One-cycle status strobes: dropped write, starved slot, slot boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underrun  <= 1'b0;
      slot_tick <= 1'b0;
    end else begin
      overflow  <= wr && !flush && !push;
      underrun  <= load_tick && !flush && fifo_empty && busy;
      slot_tick <= load_tick;
    end
  end

  // Active command registers: loaded at slot start, direction only changes on a real pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      step_dir <= '0;
      for (int i = 0; i < NUM_AXES; i++) mag[i] <= '0;
    end else if (flush) begin
      busy <= 1'b0;
      for (int i = 0; i < NUM_AXES; i++) mag[i] <= '0;
    end else if (load_tick) begin
      busy <= pop;
      for (int i = 0; i < NUM_AXES; i++) begin
        mag[i] <= pop ? head[i*VEL_W +: MAG_W] : '0;
        if (pop) step_dir[i] <= head[i*VEL_W + VEL_W - 1];
      end
    end
  end

  // DDA step decision; on a load tick the freshly popped magnitude is used directly
  always_comb begin
    fire_nxt = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      eff_mag[i] = mag[i];
      if (load_tick) eff_mag[i] = pop ? head[i*VEL_W +: MAG_W] : '0;
      sum[i]     = {1'b0, acc[i]} + {{(ACC_W + 1 - MAG_W){1'b0}}, eff_mag[i]};
      diff[i]    = sum[i] - {1'b0, n_div};
      acc_nxt[i] = acc[i];
      if (n_div != '0) begin
        if (sum[i] >= {1'b0, n_div}) begin
          fire_nxt[i] = 1'b1;
          acc_nxt[i]  = (diff[i] >= {1'b0, n_div}) ? n_div - 1'b1 : diff[i][ACC_W-1:0];
        end else begin
          acc_nxt[i] = sum[i][ACC_W-1:0];
        end
      end
    end
  end

  // Accumulators and the one-cycle fire delay that keeps step_dir ahead of the pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_q <= '0;
      for (int i = 0; i < NUM_AXES; i++) acc[i] <= ACC_RST;
    end else begin
      fire_q <= (tick && !flush) ? fire_nxt : '0;
      for (int i = 0; i < NUM_AXES; i++) begin
        if (flush)     acc[i] <= ACC_RST;
        else if (tick) acc[i] <= acc_nxt[i];
      end
    end
  end

  // Pulse stretchers; reset clears them so an active pulse ends immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_AXES; i++) pulse_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_AXES; i++) begin
        if (fire_q[i])                pulse_cnt[i] <= PULSE_LOAD;
        else if (pulse_cnt[i] != '0)  pulse_cnt[i] <= pulse_cnt[i] - 1'b1;
      end
    end
  end

  // Step outputs are high while the stretcher is counting
  always_comb begin
    step_pulse = '0;
    for (int i = 0; i < NUM_AXES; i++) step_pulse[i] = (pulse_cnt[i] != '0);
  end

endmodule
